// File: rtl/sp_ram_bist_pkg.sv
// sp_ram_bist_pkg: shared FSM states and the March C- element table
package sp_ram_bist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} bist_state_e;
  typedef struct packed {
    logic dir_down;
    logic has_read;
    logic rd_inv;
    logic has_write;
    logic wr_inv;
  } march_elem_t;
  localparam int NUM_ELEMS = 6;
  localparam march_elem_t MARCH_C_MINUS [NUM_ELEMS] = '{
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
    '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},
    '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
    '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
    '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
    '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0}
  };
endpackage

// File: rtl/sp_ram_bist_addr_gen.sv
// sp_ram_bist_addr_gen: loadable up/down word counter that saturates at the element end
module sp_ram_bist_addr_gen #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dir_down,
  input  logic         step,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);
  logic down;
  assign last_o = down ? (cnt_o == '0) : (cnt_o == '1);
  // load the element start word and direction, then walk towards the end word
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_o <= '0;
      down  <= 1'b0;
    end else if (load) begin
      cnt_o <= dir_down ? '1 : '0;
      down  <= dir_down;
    end else if (step && !last_o) begin
      cnt_o <= down ? cnt_o - 1'b1 : cnt_o + 1'b1;
    end
endmodule

// File: rtl/sp_ram_bist_ctrl.sv
// sp_ram_bist_ctrl: March C- self-test initiator for the single-port RAM
module sp_ram_bist_ctrl
  import sp_ram_bist_pkg::*;
#(
  parameter int RAM_SIZE = 32768,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PATTERN = '0
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    fail_o,
  output logic [ADDR_WIDTH-1:0]   fail_addr_o,
  output logic [DATA_WIDTH-1:0]   fail_exp_o,
  output logic [DATA_WIDTH-1:0]   fail_act_o,
  output logic                    en_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic                    we_o,
  output logic [DATA_WIDTH/8-1:0] be_o,
  input  logic [DATA_WIDTH-1:0]   rdata_i
);
  localparam int CW = ADDR_WIDTH - 2;
  localparam int BW = DATA_WIDTH / 8;
  bist_state_e state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic phase, phase_nxt, drain, drain_nxt;
  logic load, load_dir, step, last;
  logic [CW-1:0] cnt, cmp_addr;
  logic cmp_v;
  logic [DATA_WIDTH-1:0] cmp_exp;
  logic run_op, is_rd, is_wr, word_done, mismatch, start_ok;
  sp_ram_bist_addr_gen #(.W(CW)) u_addr_gen (
    .clk(clk),
    .rst(rst_i),
    .load(load),
    .dir_down(load_dir),
    .step(step),
    .cnt_o(cnt),
    .last_o(last)
  );
  assign run_op    = (state == RUN) && !drain;
  assign is_rd     = run_op && MARCH_C_MINUS[idx].has_read && !phase;
  assign is_wr     = run_op && (phase || !MARCH_C_MINUS[idx].has_read);
  assign word_done = phase || !(MARCH_C_MINUS[idx].has_read && MARCH_C_MINUS[idx].has_write);
  assign mismatch  = (state == RUN) && cmp_v && (rdata_i != cmp_exp);
  assign start_ok  = start_i && (state != RUN);
  assign busy_o    = state == RUN;
  assign done_o    = state == DONE;
  assign en_o      = run_op;
  assign we_o      = is_wr;
  assign addr_o    = run_op ? {cnt, 2'b00} : '0;
  assign wdata_o   = is_wr ? (MARCH_C_MINUS[idx].wr_inv ? ~PATTERN : PATTERN) : '0;
  assign be_o      = {BW{run_op}};
  // sequence read/write phases, words and elements; stop on mismatch or after the drain compare
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    phase_nxt = phase;
    drain_nxt = drain;
    load      = 1'b0;
    load_dir  = 1'b0;
    step      = 1'b0;
    if (start_ok) begin
      state_nxt = RUN;
      idx_nxt   = '0;
      phase_nxt = 1'b0;
      drain_nxt = 1'b0;
      load      = 1'b1;
      load_dir  = MARCH_C_MINUS[0].dir_down;
    end else if (state == RUN) begin
      if (mismatch || drain) begin
        state_nxt = DONE;
      end else if (!word_done) begin
        phase_nxt = 1'b1;
      end else if (!last) begin
        phase_nxt = 1'b0;
        step      = 1'b1;
      end else if (idx == 3'd5) begin
        drain_nxt = 1'b1;
      end else begin
        phase_nxt = 1'b0;
        idx_nxt   = idx + 3'd1;
        load      = 1'b1;
        load_dir  = MARCH_C_MINUS[idx + 3'd1].dir_down;
      end
    end
  end
  // state, sequencing registers, compare pipeline and first-fail capture
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      state       <= IDLE;
      idx         <= '0;
      phase       <= 1'b0;
      drain       <= 1'b0;
      cmp_v       <= 1'b0;
      cmp_exp     <= '0;
      cmp_addr    <= '0;
      fail_o      <= 1'b0;
      fail_addr_o <= '0;
      fail_exp_o  <= '0;
      fail_act_o  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      phase <= phase_nxt;
      drain <= drain_nxt;
      cmp_v <= is_rd;
      if (is_rd) begin
        cmp_exp  <= MARCH_C_MINUS[idx].rd_inv ? ~PATTERN : PATTERN;
        cmp_addr <= cnt;
      end
      if (start_ok) begin
        fail_o      <= 1'b0;
        fail_addr_o <= '0;
        fail_exp_o  <= '0;
        fail_act_o  <= '0;
      end else if (mismatch) begin
        fail_o      <= 1'b1;
        fail_addr_o <= {cmp_addr, 2'b00};
        fail_exp_o  <= cmp_exp;
        fail_act_o  <= rdata_i;
      end
    end
endmodule

// File: tb/tb_sp_ram_bist_ctrl.sv
// tb_sp_ram_bist_ctrl: scoreboard bench with a faultable RAM model and a March C- reference
module tb_sp_ram_bist_ctrl;
  localparam int N = 16;
  localparam logic [31:0] PAT = 32'h0;
  typedef struct {bit we; int addr; logic [31:0] data;} op_t;
  typedef struct {bit fail; int addr; logic [31:0] exp; logic [31:0] act; int busy;} res_t;
  logic clk = 1'b0, rst_i = 1'b0, start_i = 1'b0;
  logic busy_o, done_o, fail_o, en_o, we_o;
  logic [5:0] fail_addr_o, addr_o;
  logic [31:0] fail_exp_o, fail_act_o, wdata_o, rdata_i = '0;
  logic [3:0] be_o;
  int checks = 0, errors = 0;
  op_t op_q[$];
  res_t res_q[$];
  bit st_en = 0, st_val = 0, cp_en = 0;
  int st_word = 0;
  logic [31:0] st_mask = '0;
  int el_dn[6] = '{0, 0, 0, 1, 1, 0};
  int el_rd[6] = '{0, 1, 1, 1, 1, 1};
  int el_ri[6] = '{0, 0, 1, 0, 1, 0};
  int el_wr[6] = '{1, 1, 1, 1, 1, 0};
  int el_wi[6] = '{0, 1, 0, 1, 0, 0};
  always #5 clk = ~clk;
  sp_ram_bist_ctrl #(.RAM_SIZE(64), .ADDR_WIDTH(6), .DATA_WIDTH(32), .PATTERN(PAT)) dut (
    .clk(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .fail_o(fail_o), .fail_addr_o(fail_addr_o), .fail_exp_o(fail_exp_o), .fail_act_o(fail_act_o),
    .en_o(en_o), .addr_o(addr_o), .wdata_o(wdata_o), .we_o(we_o), .be_o(be_o), .rdata_i(rdata_i)
  );
  // RAM with optional stuck-at bit and a coupling fault (4th write of word 3 flips word 7)
  logic [31:0] ram [N];
  int ram_wr3 = 0;
  always @(posedge clk) begin
    if (!busy_o) ram_wr3 = 0;
    else if (en_o && we_o) begin
      ram[addr_o[5:2]] = wdata_o;
      if (addr_o[5:2] == 4'd3) begin
        ram_wr3++;
        if (cp_en && ram_wr3 == 4) ram[7] = ~ram[7];
      end
    end else if (en_o)
      rdata_i <= (st_en && int'(addr_o[5:2]) == st_word) ?
                 ((ram[addr_o[5:2]] & ~st_mask) | (st_val ? st_mask : 32'h0)) : ram[addr_o[5:2]];
  end
  // reference: walk the March C- elements over an array, return request list and verdict
  task automatic ref_run();
    op_t all[$];
    logic [31:0] m [N];
    logic [31:0] v, e;
    int wr3 = 0, fail_at = -1;
    res_t r;
    r = '{fail: 0, addr: 0, exp: 0, act: 0, busy: 10 * N + 1};
    foreach (m[i]) m[i] = '0;
    for (int el = 0; el < 6; el++)
      for (int i = 0; i < N; i++) begin
        int w;
        w = el_dn[el] != 0 ? N - 1 - i : i;
        if (el_rd[el] != 0) begin
          all.push_back('{we: 0, addr: w * 4, data: 0});
          if (fail_at < 0) begin
            v = (st_en && w == st_word) ? ((m[w] & ~st_mask) | (st_val ? st_mask : 32'h0)) : m[w];
            e = el_ri[el] != 0 ? ~PAT : PAT;
            if (v !== e) begin
              fail_at = all.size() - 1;
              r = '{fail: 1, addr: w * 4, exp: e, act: v, busy: fail_at + 2};
            end
          end
        end
        if (el_wr[el] != 0) begin
          e = el_wi[el] != 0 ? ~PAT : PAT;
          all.push_back('{we: 1, addr: w * 4, data: e});
          if (fail_at < 0) begin
            m[w] = e;
            if (w == 3) begin
              wr3++;
              if (cp_en && wr3 == 4) m[7] = ~m[7];
            end
          end
        end
      end
    for (int k = 0; k < all.size() && (fail_at < 0 || k <= fail_at + 1); k++) op_q.push_back(all[k]);
    res_q.push_back(r);
  endtask
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  // monitor: reset behaviour, request stream, start clearing and end-of-test verdicts
  bit in_rst = 0, pbusy = 0, pdone = 0;
  int bcnt = 0, wd = 0;
  always begin
    @(negedge clk or posedge rst_i);
    if (rst_i) begin
      if (!in_rst) begin
        in_rst = 1;
        #1;
        chk("rst_ctrl", {busy_o, done_o, en_o, we_o, fail_o, be_o}, 0);
        chk("rst_fail", {fail_addr_o, fail_exp_o}, 0);
        chk("rst_act", fail_act_o, 0);
        chk("rst_req", {addr_o, wdata_o}, 0);
        op_q.delete();
        res_q.delete();
        pbusy = 0;
        pdone = 0;
        wd = 0;
      end
    end else begin
      in_rst = 0;
      if (busy_o && !pbusy) begin
        chk("start_clear", {done_o, fail_o, fail_addr_o}, 0);
        chk("start_clear_data", {fail_exp_o, fail_act_o}, 0);
        bcnt = 1;
      end else if (busy_o) bcnt++;
      if (en_o) begin
        if (op_q.size() == 0) chk("op_extra", {we_o, addr_o}, 64'hDEAD);
        else begin
          op_t e;
          e = op_q.pop_front();
          chk("op", {we_o, addr_o, we_o ? wdata_o : 32'h0, be_o},
              {e.we, 6'(e.addr), e.we ? e.data : 32'h0, 4'hF});
        end
      end
      if (done_o && !pdone) begin
        if (res_q.size() == 0) chk("done_extra", done_o, 0);
        else begin
          res_t r;
          r = res_q.pop_front();
          chk("fail_o", fail_o, r.fail);
          chk("fail_addr", fail_addr_o, r.addr);
          chk("fail_exp", fail_exp_o, r.exp);
          chk("fail_act", fail_act_o, r.act);
          chk("busy_cycles", bcnt, r.busy);
          chk("ops_left", op_q.size(), 0);
        end
        wd = 0;
      end else if (res_q.size() > 0) begin
        wd++;
        if (wd > 1000) begin
          chk("timeout_wait_done", wd, 0);
          res_q.delete();
          op_q.delete();
          wd = 0;
        end
      end else wd = 0;
      pbusy = busy_o;
      pdone = done_o;
    end
  end
  task automatic pulse_start();
    @(posedge clk);
    #1 start_i = 1;
    @(posedge clk);
    #1 start_i = 0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 1500 && res_q.size() > 0; i++) @(negedge clk);
    repeat (3) @(posedge clk);
  endtask
  task automatic run_test();
    ref_run();
    pulse_start();
    wait_done();
  endtask
  initial begin
    #1000000;
    $display("FAIL global timeout");
    $fatal(1, "global timeout");
  end
  initial begin
    #2 rst_i = 1;
    repeat (2) @(posedge clk);
    #1 rst_i = 0;
    run_test();
    ref_run();
    pulse_start();
    repeat (48) @(posedge clk);
    #1 start_i = 1;
    @(posedge clk);
    #1 start_i = 0;
    wait_done();
    st_en = 1; st_word = 5; st_mask = 32'h8; st_val = 1;
    run_test();
    st_en = 0;
    run_test();
    ref_run();
    pulse_start();
    repeat (79) @(posedge clk);
    #1 rst_i = 1;
    repeat (2) @(posedge clk);
    #1 rst_i = 0;
    repeat (2) @(posedge clk);
    run_test();
    cp_en = 1;
    run_test();
    cp_en = 0;
    for (int t = 0; t < 6; t++) begin
      st_en = 1;
      st_word = $urandom_range(0, N - 1);
      st_mask = 32'h1 << $urandom_range(0, 31);
      st_val = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 5)) @(posedge clk);
      run_test();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
